// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init FSM states and mode register fields.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_LMR       = 4'b0000;

    typedef enum logic [2:0] {
        WAIT_PWR,
        PRECH,
        WAIT_RP,
        AREF,
        WAIT_RFC,
        LMR,
        WAIT_MRD,
        DONE
    } init_state_t;

    // Mode register fields: burst length [2:0], burst type [3], CAS latency [6:4]
    localparam logic [2:0] MR_BL_1         = 3'b000;
    localparam logic [2:0] MR_BL_FULL_PAGE = 3'b111;
    localparam logic       MR_BT_SEQ       = 1'b0;
    localparam logic       MR_BT_INTERLV   = 1'b1;
    localparam logic [2:0] MR_CL2          = 3'b010;
    localparam logic [2:0] MR_CL3          = 3'b011;

    function automatic logic [12:0] mode_reg_word(input logic [2:0] cl, input logic bt,
                                                  input logic [2:0] bl);
        return {6'b000000, cl, bt, bl};
    endfunction

    localparam logic [12:0] MODE_REG_DEFAULT = 13'h037;

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic refresh timer: raises a level request every REF_PERIOD cycles once init is done.
import sdram_pkg::*;

module sdram_ref_timer #(
    parameter int REF_PERIOD = 780
) (
    input  logic clk,
    input  logic rst_n,
    input  logic init_done,
    input  logic ref_ack,
    output logic ref_req,
    output logic ref_miss
);

    localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    logic [TW-1:0] timer;
    logic          wrap;
    logic          ack_valid;

    assign wrap      = init_done && (timer == TW'(REF_PERIOD - 1));
    assign ack_valid = init_done && ref_ack && ref_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= '0;
            ref_req  <= 1'b0;
            ref_miss <= 1'b0;
        end else begin
            if (!init_done || wrap) timer <= '0;
            else                    timer <= timer + 1'b1;
            // A new period's request takes priority over an acknowledge in the same cycle.
            ref_req  <= wrap | (ref_req & ~ack_valid);
            ref_miss <= wrap & ref_req & ~ack_valid;
        end
    end

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer with periodic refresh request generation.
import sdram_pkg::*;

module sdram_init_seq #(
    parameter int          T_POWERUP  = 20000,
    parameter int          T_RP       = 2,
    parameter int          T_RFC      = 7,
    parameter int          T_MRD      = 3,
    parameter int          N_AREF     = 8,
    parameter logic [12:0] MODE_REG   = 13'h037,
    parameter int          REF_PERIOD = 780
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  cmd,
    output logic [1:0]  ba,
    output logic [12:0] addr,
    output logic        init_done,
    output logic        ref_req,
    input  logic        ref_ack,
    output logic        ref_miss
);

    localparam int MAX_WAIT = (T_POWERUP > REF_PERIOD) ? T_POWERUP : REF_PERIOD;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    init_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       aref_cnt, aref_cnt_next;
    logic             pwr_loaded, pwr_loaded_next;
    logic [3:0]       cmd_next;
    logic [12:0]      addr_next;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_next      = state;
        cnt_next        = cnt;
        aref_cnt_next   = aref_cnt;
        pwr_loaded_next = pwr_loaded;
        cmd_next        = CMD_NOP;
        addr_next       = '0;

        case (state)
            WAIT_PWR: begin
                // Counter is zero out of reset, so the first cycle arms it for the remaining wait.
                if (!pwr_loaded) begin
                    pwr_loaded_next = 1'b1;
                    cnt_next        = CNT_W'(T_POWERUP - 2);
                end else if (cnt == '0) begin
                    state_next = PRECH;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            PRECH: begin
                state_next = WAIT_RP;
                cnt_next   = CNT_W'(T_RP - 1);
            end
            WAIT_RP: begin
                if (cnt == '0) state_next = AREF;
                else           cnt_next   = cnt - 1'b1;
            end
            AREF: begin
                state_next = WAIT_RFC;
                cnt_next   = CNT_W'(T_RFC - 1);
                if (aref_cnt < 4'(N_AREF)) aref_cnt_next = aref_cnt + 1'b1;
            end
            WAIT_RFC: begin
                if (cnt == '0) state_next = (aref_cnt >= 4'(N_AREF)) ? LMR : AREF;
                else           cnt_next   = cnt - 1'b1;
            end
            LMR: begin
                state_next = WAIT_MRD;
                cnt_next   = CNT_W'(T_MRD - 1);
            end
            WAIT_MRD: begin
                if (cnt == '0) state_next = DONE;
                else           cnt_next   = cnt - 1'b1;
            end
            DONE:    ;
            default: state_next = WAIT_PWR;
        endcase

        // Outputs are decoded from the next state so the registered pins line up with the state.
        case (state_next)
            PRECH: begin
                cmd_next       = CMD_PRECHARGE;
                addr_next[10]  = 1'b1;
            end
            AREF:    cmd_next = CMD_AREF;
            LMR: begin
                cmd_next  = CMD_LMR;
                addr_next = MODE_REG;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_PWR;
            cnt        <= '0;
            aref_cnt   <= '0;
            pwr_loaded <= 1'b0;
            cmd        <= CMD_NOP;
            addr       <= '0;
            init_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_next;
            cnt        <= cnt_next;
            aref_cnt   <= aref_cnt_next;
            pwr_loaded <= pwr_loaded_next;
            cmd        <= cmd_next;
            addr       <= addr_next;
            init_done  <= (state_next == DONE);
        end
    end

    // Every init command targets bank 0.
    assign ba = 2'b00;

    sdram_ref_timer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_ref_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .ref_ack   (ref_ack),
        .ref_req   (ref_req),
        .ref_miss  (ref_miss)
    );

endmodule

// File: tb/tb_sdram_init_seq.sv
// Self-checking bench for sdram_init_seq: init command stream, refresh request/ack/miss, reset.
module tb_sdram_init_seq;

    localparam int T_POWERUP  = 20;
    localparam int T_RP       = 2;
    localparam int T_RFC      = 7;
    localparam int T_MRD      = 3;
    localparam int N_AREF     = 8;
    localparam int REF_PERIOD = 50;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;

    logic        clk;
    logic        rst_n;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        init_done;
    logic        ref_req;
    logic        ref_ack;
    logic        ref_miss;

    int checks = 0;
    int errors = 0;

    logic [3:0]  q_cmd[$];
    logic [12:0] q_addr[$];

    sdram_init_seq #(
        .T_POWERUP  (T_POWERUP),
        .T_RP       (T_RP),
        .T_RFC      (T_RFC),
        .T_MRD      (T_MRD),
        .N_AREF     (N_AREF),
        .MODE_REG   (13'h037),
        .REF_PERIOD (REF_PERIOD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd),
        .ba        (ba),
        .addr      (addr),
        .init_done (init_done),
        .ref_req   (ref_req),
        .ref_ack   (ref_ack),
        .ref_miss  (ref_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] c, input logic [12:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            q_cmd.push_back(c);
            q_addr.push_back(a);
        end
    endtask

    // Expected command stream, one entry per cycle from reset release until DONE.
    task automatic build_init_seq();
        push(NOP, 13'h000, T_POWERUP);
        push(PRE, 13'h400, 1);
        push(NOP, 13'h000, T_RP);
        for (int k = 0; k < N_AREF; k++) begin
            push(REF, 13'h000, 1);
            push(NOP, 13'h000, T_RFC);
        end
        push(LMR, 13'h037, 1);
        push(NOP, 13'h000, T_MRD);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cmd"},  32'(cmd),       32'(NOP));
        chk({tag, "_ba"},   32'(ba),        32'd0);
        chk({tag, "_addr"}, 32'(addr),      32'd0);
        chk({tag, "_done"}, 32'(init_done), 32'd0);
        chk({tag, "_req"},  32'(ref_req),   32'd0);
        chk({tag, "_miss"}, 32'(ref_miss),  32'd0);
    endtask

    // Starts at the cycle-0 sample point right after reset release; random acks must be ignored.
    task automatic check_init(input string tag, input int stop_c);
        int len;
        int last;
        len  = q_cmd.size();
        last = (stop_c >= 0) ? stop_c : len;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) step();
            if (c < len) begin
                chk($sformatf("%s_cmd_c%0d", tag, c),  32'(cmd),  32'(q_cmd[c]));
                chk($sformatf("%s_addr_c%0d", tag, c), 32'(addr), 32'(q_addr[c]));
                chk($sformatf("%s_done_c%0d", tag, c), 32'(init_done), 32'd0);
            end else begin
                chk($sformatf("%s_cmd_c%0d", tag, c),  32'(cmd),  32'(NOP));
                chk($sformatf("%s_addr_c%0d", tag, c), 32'(addr), 32'd0);
                chk($sformatf("%s_done_c%0d", tag, c), 32'(init_done), 32'd1);
            end
            chk($sformatf("%s_ba_c%0d", tag, c),   32'(ba),       32'd0);
            chk($sformatf("%s_req_c%0d", tag, c),  32'(ref_req),  32'd0);
            chk($sformatf("%s_miss_c%0d", tag, c), 32'(ref_miss), 32'd0);
            ref_ack = (c < len) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    endtask

    // t=0 is the first DONE cycle. Wraps happen where t mod REF_PERIOD == REF_PERIOD-1.
    task automatic refresh_phase(input string tag, input int n_cycles);
        logic exp_req;
        logic exp_miss;
        logic a;
        logic w;
        exp_req  = 1'b0;
        exp_miss = 1'b0;
        for (int t = 0; t < n_cycles; t++) begin
            if (t > 0) step();
            chk($sformatf("%s_req_t%0d", tag, t),  32'(ref_req),   32'(exp_req));
            chk($sformatf("%s_miss_t%0d", tag, t), 32'(ref_miss),  32'(exp_miss));
            chk($sformatf("%s_done_t%0d", tag, t), 32'(init_done), 32'd1);
            chk($sformatf("%s_cmd_t%0d", tag, t),  32'(cmd),       32'(NOP));
            chk($sformatf("%s_addr_t%0d", tag, t), 32'(addr),      32'd0);
            if (t == 49)  chk("t2_req_before_period", 32'(ref_req), 32'd0);
            if (t == 50)  chk("t2_req_rise",          32'(ref_req), 32'd1);
            if (t == 100) chk("t2_miss_first",        32'(ref_miss), 32'd1);
            if (t == 101) chk("t2_miss_one_cycle",    32'(ref_miss), 32'd0);
            if (t == 150) chk("t2_miss_second",       32'(ref_miss), 32'd1);
            if (t == 171) chk("t3_req_cleared",       32'(ref_req), 32'd0);
            if (t == 200) chk("t3_req_rise",          32'(ref_req), 32'd1);
            if (t == 204) chk("t3_req_ack_clear",     32'(ref_req), 32'd0);
            if (t == 250) chk("t3_req_no_drift",      32'(ref_req), 32'd1);
            if (t == 300) begin
                chk("t4_req_set_wins",  32'(ref_req),  32'd1);
                chk("t4_no_miss",       32'(ref_miss), 32'd0);
            end
            a = (t == 170) || (t == 203) || (t == 299) ||
                (t >= 300 && $urandom_range(0, 7) == 0);
            ref_ack = a;
            w = ((t % REF_PERIOD) == REF_PERIOD - 1);
            exp_miss = w && exp_req && !a;
            exp_req  = w ? 1'b1 : ((a && exp_req) ? 1'b0 : exp_req);
        end
        ref_ack = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        ref_ack = 1'b0;
        build_init_seq();

        repeat (3) step();
        check_reset("rst_initial");
        rst_n = 1'b1;
        check_init("init1", -1);
        refresh_phase("ref1", 600);

        // Reset while in DONE restarts everything.
        rst_n = 1'b0;
        #1;
        check_reset("rst_in_done");
        repeat (2) step();
        rst_n = 1'b1;

        // Reset again during the 4th AREF wait (cycle 50 lies in 48..54).
        check_init("init2", 50);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid_aref");
        repeat (2) step();
        check_reset("rst_held");
        rst_n = 1'b1;
        check_init("init3", -1);
        refresh_phase("ref3", 120);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
